// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC capture sequencer: FSM states,
// ADC register offsets, AXI response codes and sticky error codes.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_CFG,
    ST_W_GO,
    ST_R_STAT,
    ST_R_DATA,
    ST_OUT,
    ST_W_CLR,
    ST_ERR
  } state_e;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_CFG  = 4'h4;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_DATA = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_WRESP   = 2'b01;
  localparam logic [1:0] ERR_RRESP   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic is_write_state(input state_e s);
    return s inside {ST_W_CFG, ST_W_GO, ST_W_CLR};
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// AXI4-Lite bus bundle between the capture sequencer (master) and the
// ADC register block (slave).
interface adc_capture_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_single_txn.sv
// Single-transaction AXI4-Lite master engine: a one-cycle req launches one
// write or read; done pulses in the response handshake cycle with resp/rdata.
module axil_single_txn #(
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [31:0]            wdata,
  output logic                   done,
  output logic [31:0]            rdata,
  output logic [1:0]             resp,
  adc_capture_sequencer_if.master m_axi
);

  logic              aw_q, aw_d, w_q, w_d, b_q, b_d;
  logic              ar_q, ar_d, r_q, r_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    aw_d     = aw_q;
    w_d      = w_q;
    b_d      = b_q;
    ar_d     = ar_q;
    r_d      = r_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    wdata_d  = wdata_q;
    if (req) begin
      if (we) begin
        aw_d     = 1'b1;
        w_d      = 1'b1;
        b_d      = 1'b1;
        awaddr_d = addr;
        wdata_d  = wdata;
      end else begin
        ar_d     = 1'b1;
        r_d      = 1'b1;
        araddr_d = addr;
      end
    end else begin
      // AW and W retire independently; response readies hold until their VALID
      if (m_axi.awready) aw_d = 1'b0;
      if (m_axi.wready)  w_d  = 1'b0;
      if (m_axi.bvalid)  b_d  = 1'b0;
      if (m_axi.arready) ar_d = 1'b0;
      if (m_axi.rvalid)  r_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      b_q      <= 1'b0;
      ar_q     <= 1'b0;
      r_q      <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      aw_q     <= aw_d;
      w_q      <= w_d;
      b_q      <= b_d;
      ar_q     <= ar_d;
      r_q      <= r_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = aw_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = w_q;
  assign m_axi.bready  = b_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = ar_q;
  assign m_axi.rready  = r_q;

  assign done  = (b_q && m_axi.bvalid) || (r_q && m_axi.rvalid);
  assign rdata = m_axi.rdata;
  assign resp  = r_q ? m_axi.rresp : m_axi.bresp;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Sequences one ADC conversion over AXI4-Lite: write CFG, set GO, poll STATUS,
// read DATA, present the sample on valid/ready, then clear CTRL.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                POLL_MAX  = 1024
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   start,
  input  logic [31:0]            cfg_word,
  output logic                   busy,
  output logic [31:0]            smp_data,
  output logic                   smp_valid,
  input  logic                   smp_ready,
  output logic                   err,
  output logic [1:0]             err_code,
  adc_capture_sequencer_if.master m_axi
);

  localparam int             PW       = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0]  POLL_LIM = PW'(POLL_MAX);

  state_e            state_q, state_d;
  logic [31:0]       cfg_q, cfg_d, smp_q, smp_d;
  logic [1:0]        code_q, code_d;
  logic [PW-1:0]     poll_q, poll_d, poll_inc;
  logic              pend_q, pend_d;

  logic              txn_state, txn_req, txn_we, txn_done;
  logic [3:0]        txn_off;
  logic [ADDR_W-1:0] txn_addr;
  logic [31:0]       txn_wdata, txn_rdata;
  logic [1:0]        txn_resp;
  logic              resp_ok;

  // One transaction per bus state visit; pend_q blocks a re-issue until done
  always_comb begin
    txn_state = state_q inside {ST_W_CFG, ST_W_GO, ST_R_STAT, ST_R_DATA, ST_W_CLR};
    txn_req   = txn_state && !pend_q;
    txn_we    = is_write_state(state_q);
    txn_off   = REG_CTRL;
    txn_wdata = 32'd0;
    case (state_q)
      ST_W_CFG: begin
        txn_off   = REG_CFG;
        txn_wdata = cfg_q;
      end
      ST_W_GO:   txn_wdata = 32'd1;
      ST_R_STAT: txn_off   = REG_STAT;
      ST_R_DATA: txn_off   = REG_DATA;
      default:   ;
    endcase
    txn_addr = BASE_ADDR + ADDR_W'(txn_off);
  end

  axil_single_txn #(.ADDR_W(ADDR_W)) u_txn (
    .clk   (ACLK),
    .rst   (ARESET),
    .req   (txn_req),
    .we    (txn_we),
    .addr  (txn_addr),
    .wdata (txn_wdata),
    .done  (txn_done),
    .rdata (txn_rdata),
    .resp  (txn_resp),
    .m_axi (m_axi)
  );

  assign resp_ok  = (txn_resp == RESP_OKAY);
  assign poll_inc = poll_q + PW'(1);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    smp_d   = smp_q;
    code_d  = code_q;
    poll_d  = poll_q;
    pend_d  = pend_q;
    if (txn_req)  pend_d = 1'b1;
    if (txn_done) pend_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_W_CFG;
          cfg_d   = cfg_word;
          code_d  = ERR_NONE;
        end
      end
      ST_W_CFG: begin
        if (txn_done) begin
          state_d = resp_ok ? ST_W_GO : ST_ERR;
          if (!resp_ok) code_d = ERR_WRESP;
        end
      end
      ST_W_GO: begin
        poll_d = '0;
        if (txn_done) begin
          state_d = resp_ok ? ST_R_STAT : ST_ERR;
          if (!resp_ok) code_d = ERR_WRESP;
        end
      end
      ST_R_STAT: begin
        if (txn_done) begin
          if (!resp_ok) begin
            state_d = ST_ERR;
            code_d  = ERR_RRESP;
          end else if (txn_rdata[0]) begin
            state_d = ST_R_DATA;
          end else if (poll_inc == POLL_LIM) begin
            state_d = ST_ERR;
            code_d  = ERR_TIMEOUT;
          end else begin
            poll_d = poll_inc;
          end
        end
      end
      ST_R_DATA: begin
        if (txn_done) begin
          if (resp_ok) begin
            state_d = ST_OUT;
            smp_d   = txn_rdata;
          end else begin
            state_d = ST_ERR;
            code_d  = ERR_RRESP;
          end
        end
      end
      ST_OUT: begin
        if (smp_ready) state_d = ST_W_CLR;
      end
      ST_W_CLR: begin
        if (txn_done) begin
          state_d = resp_ok ? ST_IDLE : ST_ERR;
          if (!resp_ok) code_d = ERR_WRESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      smp_q   <= '0;
      code_q  <= ERR_NONE;
      poll_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      smp_q   <= smp_d;
      code_q  <= code_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
    end
  end

  assign busy      = !(state_q inside {ST_IDLE, ST_ERR});
  assign smp_valid = (state_q == ST_OUT);
  assign smp_data  = smp_q;
  assign err       = (state_q == ST_ERR);
  assign err_code  = code_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench: two sequencers (default POLL_MAX at base 0, POLL_MAX=4 at a
// non-zero base) share one behavioural ADC register slave selected by sel.
module tb_adc_capture_sequencer;

  localparam logic [31:0] BASE_B = 32'h4000_0010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sel, smp_ready;
  logic [31:0] cfg_word;
  logic        start_a, start_b;
  assign start_a = start && !sel;
  assign start_b = start && sel;

  logic        busy_a, busy_b, smp_valid_a, smp_valid_b, err_a, err_b;
  logic [31:0] smp_data_a, smp_data_b;
  logic [1:0]  err_code_a, err_code_b;

  adc_capture_sequencer_if #(.ADDR_W(32)) axi_a ();
  adc_capture_sequencer_if #(.ADDR_W(32)) axi_b ();

  adc_capture_sequencer #(.ADDR_W(32), .BASE_ADDR(32'h0), .POLL_MAX(1024)) dut_a (
    .ACLK(clk), .ARESET(rst), .start(start_a), .cfg_word(cfg_word), .busy(busy_a),
    .smp_data(smp_data_a), .smp_valid(smp_valid_a), .smp_ready(smp_ready),
    .err(err_a), .err_code(err_code_a), .m_axi(axi_a));

  adc_capture_sequencer #(.ADDR_W(32), .BASE_ADDR(BASE_B), .POLL_MAX(4)) dut_b (
    .ACLK(clk), .ARESET(rst), .start(start_b), .cfg_word(cfg_word), .busy(busy_b),
    .smp_data(smp_data_b), .smp_valid(smp_valid_b), .smp_ready(smp_ready),
    .err(err_b), .err_code(err_code_b), .m_axi(axi_b));

  // Selected sequencer's outputs
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy_m, smp_valid_m, err_m;
  logic [31:0] m_awaddr, m_wdata, m_araddr, smp_data_m;
  logic [3:0]  m_wstrb;
  logic [1:0]  err_code_m;
  assign m_awvalid   = sel ? axi_b.awvalid : axi_a.awvalid;
  assign m_awaddr    = sel ? axi_b.awaddr  : axi_a.awaddr;
  assign m_wvalid    = sel ? axi_b.wvalid  : axi_a.wvalid;
  assign m_wdata     = sel ? axi_b.wdata   : axi_a.wdata;
  assign m_wstrb     = sel ? axi_b.wstrb   : axi_a.wstrb;
  assign m_bready    = sel ? axi_b.bready  : axi_a.bready;
  assign m_arvalid   = sel ? axi_b.arvalid : axi_a.arvalid;
  assign m_araddr    = sel ? axi_b.araddr  : axi_a.araddr;
  assign m_rready    = sel ? axi_b.rready  : axi_a.rready;
  assign busy_m      = sel ? busy_b        : busy_a;
  assign smp_valid_m = sel ? smp_valid_b   : smp_valid_a;
  assign smp_data_m  = sel ? smp_data_b    : smp_data_a;
  assign err_m       = sel ? err_b         : err_a;
  assign err_code_m  = sel ? err_code_b    : err_code_a;

  // Slave-driven signals fan out to both buses
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  assign axi_a.awready = s_awready;  assign axi_b.awready = s_awready;
  assign axi_a.wready  = s_wready;   assign axi_b.wready  = s_wready;
  assign axi_a.bvalid  = s_bvalid;   assign axi_b.bvalid  = s_bvalid;
  assign axi_a.bresp   = s_bresp;    assign axi_b.bresp   = s_bresp;
  assign axi_a.arready = s_arready;  assign axi_b.arready = s_arready;
  assign axi_a.rvalid  = s_rvalid;   assign axi_b.rvalid  = s_rvalid;
  assign axi_a.rresp   = s_rresp;    assign axi_b.rresp   = s_rresp;
  assign axi_a.rdata   = s_rdata;    assign axi_b.rdata   = s_rdata;

  // Slave configuration and transaction log
  int          cfg_aw_delay, cfg_done_on, cyc, aw_wait, stat_cnt, bus_act;
  logic        cfg_stat_err;
  logic [31:0] cfg_data;
  logic        p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  int          aw_cyc, w_cyc, wr_n, rd_n;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [31:0] rd_addr [16];
  int          wr_awc [16];
  int          wr_wc [16];
  int          wr_cyc [16];

  task automatic slave_step();
    if (rst) begin
      {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
      {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got} = '0;
      aw_wait = 0; aw_cyc = 0; w_cyc = 0;
    end else begin
      if (m_awvalid) aw_cyc++;
      if (m_wvalid) w_cyc++;
      if (m_awvalid || m_wvalid || m_arvalid) bus_act++;
      if (p_aw) aw_got = 1'b1;
      if (p_w)  w_got  = 1'b1;
      if (p_b)  s_bvalid = 1'b0;
      if (p_ar) ar_got = 1'b1;
      if (p_r)  s_rvalid = 1'b0;
      if (aw_got && w_got && !s_bvalid) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = cap_awaddr; wr_data[wr_n] = cap_wdata;
          wr_awc[wr_n] = aw_cyc; wr_wc[wr_n] = w_cyc; wr_cyc[wr_n] = cyc;
        end
        wr_n++;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; aw_cyc = 0; w_cyc = 0;
      end
      if (ar_got && !s_rvalid) begin
        if (rd_n < 16) rd_addr[rd_n] = cap_araddr;
        rd_n++;
        if (cap_araddr[3:0] == 4'h8) begin
          stat_cnt++;
          s_rdata = (cfg_done_on != 0 && stat_cnt >= cfg_done_on) ? 32'd1 : 32'd0;
          s_rresp = cfg_stat_err ? 2'b10 : 2'b00;
        end else begin
          s_rdata = cfg_data; s_rresp = 2'b00;
        end
        s_rvalid = 1'b1; ar_got = 1'b0;
      end
      if (m_awvalid && !aw_got) begin
        if (aw_wait >= cfg_aw_delay) s_awready = 1'b1;
        else begin s_awready = 1'b0; aw_wait++; end
      end else begin
        s_awready = 1'b0; aw_wait = 0;
      end
      s_wready = 1'b1; s_arready = 1'b1;
      p_aw = m_awvalid && s_awready; if (p_aw) cap_awaddr = m_awaddr;
      p_w  = m_wvalid && s_wready;   if (p_w)  cap_wdata  = m_wdata;
      p_ar = m_arvalid && s_arready; if (p_ar) cap_araddr = m_araddr;
      p_b  = s_bvalid && m_bready;
      p_r  = s_rvalid && m_rready;
    end
  endtask

  initial begin
    {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = '0;
    s_bresp = '0; s_rresp = '0; s_rdata = '0;
    {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got} = '0;
    cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0;
    cyc = 0; aw_wait = 0; aw_cyc = 0; w_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      slave_step();
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_n = 0; rd_n = 0; stat_cnt = 0; bus_act = 0;
  endtask

  logic [31:0] smp_first;
  logic        unstable, err_after_start;
  logic [1:0]  code_after_start;
  int          vcyc, acc_cyc, seq_n;

  task automatic run_seq(input logic [31:0] cfg, input int rdy_delay);
    logic first;
    clear_logs();
    cfg_word = cfg; start = 1'b1;
    step();
    start = 1'b0;
    err_after_start = err_m; code_after_start = err_code_m;
    seq_n = 0; vcyc = 0; first = 1'b1; unstable = 1'b0; acc_cyc = -1; smp_first = '0;
    while (busy_m && seq_n < 600) begin
      if (smp_valid_m) begin
        if (first) begin smp_first = smp_data_m; first = 1'b0; end
        else if (smp_data_m !== smp_first) unstable = 1'b1;
        smp_ready = (vcyc >= rdy_delay);
        if (smp_ready) acc_cyc = cyc;
        vcyc++;
      end else begin
        smp_ready = 1'b0;
      end
      step();
      seq_n++;
    end
    smp_ready = 1'b0;
    check_val("seq_finished_in_budget", 32'(seq_n < 600), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; smp_ready = 1'b0; cfg_word = '0;
    cfg_aw_delay = 0; cfg_done_on = 1; cfg_stat_err = 1'b0; cfg_data = '0;
    wr_n = 0; rd_n = 0; stat_cnt = 0; bus_act = 0;
    repeat (3) step();

    check_val("rst_busy",      32'(busy_a),      32'd0);
    check_val("rst_smp_valid", 32'(smp_valid_a), 32'd0);
    check_val("rst_err",       32'(err_a),       32'd0);
    check_val("rst_err_code",  32'(err_code_a),  32'd0);
    check_val("rst_smp_data",  smp_data_a,       32'd0);
    check_val("rst_awvalid",   32'(m_awvalid),   32'd0);
    check_val("rst_wvalid",    32'(m_wvalid),    32'd0);
    check_val("rst_bready",    32'(m_bready),    32'd0);
    check_val("rst_arvalid",   32'(m_arvalid),   32'd0);
    check_val("rst_rready",    32'(m_rready),    32'd0);
    check_val("rst_awaddr",    m_awaddr,         32'd0);
    check_val("rst_araddr",    m_araddr,         32'd0);
    check_val("rst_wdata",     m_wdata,          32'd0);
    check_val("rst_wstrb",     32'(m_wstrb),     32'hF);
    check_val("rst_busy_b",    32'(busy_b),      32'd0);
    rst = 1'b0;
    step();

    // Zero-wait slave, status done on first poll
    cfg_data = 32'h1234; cfg_done_on = 1;
    run_seq(32'hA5, 0);
    check_val("t1_wr_n",   32'(wr_n), 32'd3);
    check_val("t1_wr0_a",  wr_addr[0], 32'h4);
    check_val("t1_wr0_d",  wr_data[0], 32'hA5);
    check_val("t1_wr1_a",  wr_addr[1], 32'h0);
    check_val("t1_wr1_d",  wr_data[1], 32'h1);
    check_val("t1_wr2_a",  wr_addr[2], 32'h0);
    check_val("t1_wr2_d",  wr_data[2], 32'h0);
    check_val("t1_rd_n",   32'(rd_n), 32'd2);
    check_val("t1_rd0_a",  rd_addr[0], 32'h8);
    check_val("t1_rd1_a",  rd_addr[1], 32'hC);
    check_val("t1_sample", smp_first, 32'h1234);
    check_val("t1_err",    32'(err_m), 32'd0);
    check_val("t1_busy",   32'(busy_m), 32'd0);

    // Status done on fifth read
    cfg_data = 32'h5A5A_0001; cfg_done_on = 5;
    run_seq(32'h11, 0);
    check_val("t2_rd_n",    32'(rd_n), 32'd6);
    check_val("t2_stat_n",  32'(stat_cnt), 32'd5);
    check_val("t2_rd4_a",   rd_addr[4], 32'h8);
    check_val("t2_rd5_a",   rd_addr[5], 32'hC);
    check_val("t2_wr_n",    32'(wr_n), 32'd3);
    check_val("t2_sample",  smp_first, 32'h5A5A_0001);
    check_val("t2_busy",    32'(busy_m), 32'd0);

    // POLL_MAX=4 instance, done never set
    sel = 1'b1; cfg_done_on = 0;
    step();
    run_seq(32'h33, 0);
    check_val("t3_rd_n",     32'(rd_n), 32'd4);
    check_val("t3_rd3_a",    rd_addr[3], BASE_B + 32'h8);
    check_val("t3_wr0_a",    wr_addr[0], BASE_B + 32'h4);
    check_val("t3_wr_n",     32'(wr_n), 32'd2);
    check_val("t3_err",      32'(err_m), 32'd1);
    check_val("t3_err_code", 32'(err_code_m), 32'd3);
    check_val("t3_busy",     32'(busy_m), 32'd0);
    bus_act = 0;
    repeat (6) step();
    check_val("t3_bus_idle", 32'(bus_act), 32'd0);
    check_val("t3_err_sticky", 32'(err_m), 32'd1);
    cfg_done_on = 1; cfg_data = 32'hCAFE;
    run_seq(32'h44, 0);
    check_val("t3_restart_err",  32'(err_after_start), 32'd0);
    check_val("t3_restart_code", 32'(code_after_start), 32'd0);
    check_val("t3_restart_rd_n", 32'(rd_n), 32'd2);
    check_val("t3_restart_rd1",  rd_addr[1], BASE_B + 32'hC);
    check_val("t3_restart_smp",  smp_first, 32'hCAFE);
    check_val("t3_restart_err2", 32'(err_m), 32'd0);

    // AWREADY delayed 3 cycles, consumer stalls 10 cycles
    sel = 1'b0; cfg_aw_delay = 3; cfg_data = 32'h0BAD_F00D;
    step();
    run_seq(32'h55, 10);
    check_val("t4_awvalid_cycles", 32'(wr_awc[0]), 32'd4);
    check_val("t4_wvalid_cycles",  32'(wr_wc[0]), 32'd1);
    check_val("t4_sample",         smp_first, 32'h0BAD_F00D);
    check_val("t4_stable",         32'(unstable), 32'd0);
    check_val("t4_valid_cycles",   32'(vcyc), 32'd11);
    check_val("t4_clr_after_acc",  32'(wr_cyc[2] > acc_cyc && acc_cyc >= 0), 32'd1);
    check_val("t4_wr2_d",          wr_data[2], 32'h0);

    // SLVERR on STATUS read
    cfg_aw_delay = 0; cfg_stat_err = 1'b1;
    run_seq(32'h66, 0);
    check_val("t5_err",      32'(err_m), 32'd1);
    check_val("t5_err_code", 32'(err_code_m), 32'd2);
    check_val("t5_rd_n",     32'(rd_n), 32'd1);
    bus_act = 0;
    repeat (5) step();
    check_val("t5_bus_idle", 32'(bus_act), 32'd0);
    cfg_stat_err = 1'b0;

    // Reset pulsed while the CFG write is in flight
    cfg_word = 32'h77; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_val("t6_awvalid_pre", 32'(m_awvalid), 32'd1);
    rst = 1'b1;
    step();
    check_val("t6_awvalid",  32'(m_awvalid), 32'd0);
    check_val("t6_wvalid",   32'(m_wvalid), 32'd0);
    check_val("t6_bready",   32'(m_bready), 32'd0);
    check_val("t6_awaddr",   m_awaddr, 32'd0);
    check_val("t6_wdata",    m_wdata, 32'd0);
    check_val("t6_busy",     32'(busy_m), 32'd0);
    check_val("t6_err",      32'(err_m), 32'd0);
    check_val("t6_smp_data", smp_data_m, 32'd0);
    rst = 1'b0;
    step();
    cfg_data = 32'h9;
    run_seq(32'h78, 0);
    check_val("t6_rerun_wr_n", 32'(wr_n), 32'd3);
    check_val("t6_rerun_wr0",  wr_data[0], 32'h78);
    check_val("t6_rerun_smp",  smp_first, 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
